fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the RISCAT pipeline: owns the program counter, issues reads to a synchronous instruction memory, and produces the `IF_ID` stage register consumed by the decode stage. Supports downstream stall with a one-entry hold buffer so no fetched word is lost. Taken jumps resolved in EX redirect the PC, and wrong-path words are squashed by marking them `do_not_execute`.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC value after reset.

Ports:
- `clk`  input  1  sole clock; all state updates on its rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `stall`  input  1  downstream cannot accept a new `if_id_r` this cycle.
- `redirect_valid`  input  1  taken jump from EX this cycle.
- `redirect_pc`  input  32  jump target.
- `imem_addr`  output  32  read address; equals `pc_q`.
- `imem_rd_en`  output  1  read strobe.
- `imem_rdata`  input  32  word for the address accepted on the previous edge.
- `if_id_r`  output  `IF_ID`  fields `pc`, `fetched_inst`, `do_not_execute`.
- `fetch_misaligned`  output  1  sticky misaligned-target flag. Tied 0 unless the macro is defined.

## Operation
- State:
  - `pc_q` (32): next address to issue.
  - `req_valid_q`, `req_pc_q`: a read was issued last cycle.
  - `hold_valid_q`, `hold_pc_q`, `hold_inst_q`: word captured during a stall.
  - `halted_q`: set only by the macro feature.
- Reset values:
  - `pc_q = RESET_PC`; all valid flags 0.
  - `if_id_r = {pc:0, fetched_inst:32'h0000_0013, do_not_execute:1}`.
  - `fetch_misaligned = 0`.
- `imem_rd_en = !stall && !redirect_valid && !halted_q`.
- On an issue edge (`imem_rd_en=1`): `pc_q <= pc_q + 4` (mod 2^32; wraps from `FFFF_FFFC` to 0), `req_valid_q <= 1`, `req_pc_q <= pc_q`. Otherwise `req_valid_q <= 0`.
- Output update when `!stall`, priority order:
  1. If `hold_valid_q`: `if_id_r <= {hold_pc_q, hold_inst_q, 0}` and clear `hold_valid_q`.
  2. Else if `req_valid_q`: `if_id_r <= {req_pc_q, imem_rdata, 0}`.
  3. Else: bubble `{req_pc_q, 32'h13, 1}`.
- Stall: `if_id_r` and `pc_q` hold. If `req_valid_q` is 1 in a stall cycle, capture `{req_pc_q, imem_rdata}` into the hold buffer. At most one capture is possible, because no read is issued while stalled.
- Redirect has priority over stall and hold:
  - `pc_q <= redirect_pc`
  - `req_valid_q <= 0`, `hold_valid_q <= 0`
  - `if_id_r.do_not_execute <= 1`, with `pc` and `fetched_inst` unchanged.
- Flushing ID/EX and later stages is outside this block.

## Timing
- Steady state: the word at address A is issued in cycle N and appears in `if_id_r` after edge N+1. Throughput is 1 per cycle.
- After reset release: `imem_addr = RESET_PC` in the first cycle. The first valid `if_id_r` appears after the second edge.
- Redirect in cycle N:
  - Edge N: bubble.
  - Cycle N+1: `imem_addr = target`.
  - Edge N+1: bubble.
  - Edge N+2: `{target, word, 0}`.
  - Exactly 2 bubbles.
- Stall asserted cycles S..S+k−1: `if_id_r` constant. First edge after release presents the held word; the next edge presents the word at the following PC. No gap, no duplicate.
- Redirect and stall in the same cycle: redirect wins; the hold buffer is discarded.
- Reset mid-stream: asynchronous return to reset values. An in-flight `imem_rdata` is ignored.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0] != 0` sets `fetch_misaligned` and `halted_q` (sticky until reset).
  - `pc_q` keeps the misaligned target; `imem_rd_en` stays 0; only bubbles are emitted.
- Not defined:
  - `redirect_pc[1:0]` is forced to `2'b00`.
  - `fetch_misaligned` is tied 0 and `halted_q` does not exist.

## Test plan
- Reset release with `RESET_PC=0x100` and memory word = 0x00500093 at every address → `if_id_r` shows pc 0x100, then 0x104, then 0x108, with `do_not_execute=0`. Cycle 1 after release is a bubble.
- Stall for 3 cycles while streaming → the word at 0x108 is held in the hold buffer; after release `if_id_r` shows 0x108 then 0x10C, with no skip and no repeat.
- `redirect_valid` with `redirect_pc=0x200` → exactly 2 outputs with `do_not_execute=1`, then pc 0x200; `imem_addr = 0x200` one cycle after the redirect.
- Redirect and stall asserted together, with the hold buffer full → the held word never appears; the first valid output is pc = target.
- `RESET_PC=0xFFFF_FFF8` → pcs FFF8, FFFC, 0000, 0004.
- With `FETCH_ALIGN_CHECK_EN`, redirect to 0x202 → `fetch_misaligned=1`, `imem_rd_en=0`, bubbles only until `reset_n` is pulsed. Without the macro, the same redirect fetches from 0x200.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a synchronous instruction memory and drives IF_ID.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned redirect targets halt fetch and raise fetch_misaligned.

package fetch_unit_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] fetched_inst;
    logic        do_not_execute;
  } if_id_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
endpackage

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic [31:0]            imem_addr,
  output logic                   imem_rd_en,
  input  logic [31:0]            imem_rdata,
  output fetch_unit_pkg::if_id_t if_id_r,
  output logic                   fetch_misaligned
);
  import fetch_unit_pkg::*;

  logic [31:0] pc_q, pc_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  if_id_t      if_id_q, if_id_d;

  logic [31:0] target;
  logic        halted;

`ifdef FETCH_ALIGN_CHECK_EN
  logic halted_q, halted_d;
  logic bad_target;

  assign target           = redirect_pc;
  assign bad_target       = (redirect_pc[1:0] != 2'b00);
  assign halted           = halted_q;
  assign fetch_misaligned = halted_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  always_comb begin
    halted_d = halted_q;
    if (redirect_valid && bad_target) begin
      halted_d = 1'b1;
    end
  end
`else
  logic unused_low_bits;

  // Low target bits are dropped: without the check every target is word aligned.
  assign target           = {redirect_pc[31:2], 2'b00};
  assign unused_low_bits  = ^redirect_pc[1:0];
  assign halted           = 1'b0;
  assign fetch_misaligned = 1'b0;
`endif

  assign imem_rd_en = !stall && !redirect_valid && !halted;
  assign imem_addr  = pc_q;
  assign if_id_r    = if_id_q;

  always_comb begin
    pc_d         = pc_q;
    req_valid_d  = req_valid_q;
    req_pc_d     = req_pc_q;
    hold_valid_d = hold_valid_q;
    hold_pc_d    = hold_pc_q;
    hold_inst_d  = hold_inst_q;
    if_id_d      = if_id_q;

    if (redirect_valid) begin
      // Once halted the misaligned target stays in the PC.
      if (!halted) begin
        pc_d = target;
      end
      req_valid_d            = 1'b0;
      hold_valid_d           = 1'b0;
      if_id_d.do_not_execute = 1'b1;
    end else begin
      req_valid_d = imem_rd_en;
      if (imem_rd_en) begin
        pc_d     = pc_q + 32'd4;
        req_pc_d = pc_q;
      end

      if (!stall) begin
        hold_valid_d = 1'b0;
        if (hold_valid_q) begin
          if_id_d = '{pc: hold_pc_q, fetched_inst: hold_inst_q, do_not_execute: 1'b0};
        end else if (req_valid_q) begin
          if_id_d = '{pc: req_pc_q, fetched_inst: imem_rdata, do_not_execute: 1'b0};
        end else begin
          if_id_d = '{pc: req_pc_q, fetched_inst: NOP_INST, do_not_execute: 1'b1};
        end
      end else if (req_valid_q) begin
        // Memory data is only valid for one cycle, so park it until the stall clears.
        hold_valid_d = 1'b1;
        hold_pc_d    = req_pc_q;
        hold_inst_d  = imem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q         <= RESET_PC;
      req_valid_q  <= 1'b0;
      req_pc_q     <= 32'h0;
      hold_valid_q <= 1'b0;
      hold_pc_q    <= 32'h0;
      hold_inst_q  <= 32'h0;
      if_id_q      <= '{pc: 32'h0, fetched_inst: NOP_INST, do_not_execute: 1'b1};
    end else begin
      pc_q         <= pc_d;
      req_valid_q  <= req_valid_d;
      req_pc_q     <= req_pc_d;
      hold_valid_q <= hold_valid_d;
      hold_pc_q    <= hold_pc_d;
      hold_inst_q  <= hold_inst_d;
      if_id_q      <= if_id_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed test-plan sequences plus random stall/redirect traffic
// checked against an in-order stream model of issued fetch addresses.

module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] PC0 = 32'h0000_0100;
  localparam logic [31:0] PCW = 32'hFFFF_FFF8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, w_imem_addr;
  logic        imem_rd_en, w_imem_rd_en;
  logic [31:0] imem_rdata, w_imem_rdata;
  if_id_t      if_id_r, w_if_id_r;
  logic        fetch_misaligned, w_fetch_misaligned;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [31:0] m_pc;
  int          m_edge;
  logic [31:0] exp_q[$];
  int          iss_q[$];
  logic [31:0] e_pc, e_inst;
  logic        e_dne, e_pc_ok;

  fetch_unit #(.RESET_PC(PC0)) u_dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rd_en(imem_rd_en),
    .imem_rdata(imem_rdata), .if_id_r(if_id_r), .fetch_misaligned(fetch_misaligned)
  );

  fetch_unit #(.RESET_PC(PCW)) u_wrap (
    .clk(clk), .reset_n(reset_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(w_imem_addr), .imem_rd_en(w_imem_rd_en),
    .imem_rdata(w_imem_rdata), .if_id_r(w_if_id_r), .fetch_misaligned(w_fetch_misaligned)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0050_0093;
  endfunction

  // synchronous instruction memories; data is garbage when no read was accepted
  always @(posedge clk) begin
    imem_rdata   <= imem_rd_en   ? mem_word(imem_addr)   : 32'hBADC_0FFE;
    w_imem_rdata <= w_imem_rd_en ? mem_word(w_imem_addr) : 32'hBADC_0FFE;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = PC0;
    m_edge  = 0;
    exp_q.delete();
    iss_q.delete();
    e_pc    = 32'h0;
    e_inst  = NOP;
    e_dne   = 1'b1;
    e_pc_ok = 1'b1;
  endtask

  // Every accepted read yields exactly one valid output, in issue order, no earlier
  // than the edge after issue; a redirect discards everything not yet delivered.
  task automatic model_edge(input logic st, input logic rv, input logic [31:0] tgt);
    m_edge++;
    if (rv) begin
      m_pc  = {tgt[31:2], 2'b00};
      exp_q.delete();
      iss_q.delete();
      e_dne = 1'b1;
    end else if (!st) begin
      if (exp_q.size() > 0 && iss_q[0] < m_edge) begin
        e_pc    = exp_q.pop_front();
        void'(iss_q.pop_front());
        e_inst  = mem_word(e_pc);
        e_dne   = 1'b0;
        e_pc_ok = 1'b1;
      end else begin
        e_inst  = NOP;
        e_dne   = 1'b1;
        e_pc_ok = 1'b0;
      end
      exp_q.push_back(m_pc);
      iss_q.push_back(m_edge);
      m_pc = m_pc + 32'd4;
    end
  endtask

  // driver: one clock cycle with given inputs, checked before and after the edge
  task automatic step(input logic st, input logic rv, input logic [31:0] tgt);
    @(negedge clk);
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = tgt;
    #1;
    chk("rd_en", {31'h0, imem_rd_en}, {31'h0, (!st && !rv)});
    chk("imem_addr", imem_addr, m_pc);
    @(posedge clk);
    model_edge(st, rv, tgt);
    #1;
    chk("dne", {31'h0, if_id_r.do_not_execute}, {31'h0, e_dne});
    chk("inst", if_id_r.fetched_inst, e_inst);
    if (e_pc_ok) chk("pc", if_id_r.pc, e_pc);
    chk("misaligned", {31'h0, fetch_misaligned}, 32'h0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"}, if_id_r.pc, 32'h0);
    chk({tag, "_inst"}, if_id_r.fetched_inst, NOP);
    chk({tag, "_dne"}, {31'h0, if_id_r.do_not_execute}, 32'h1);
    chk({tag, "_addr"}, imem_addr, PC0);
    chk({tag, "_mis"}, {31'h0, fetch_misaligned}, 32'h0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_reset_state("mid_rst");
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    model_reset();
  endtask

  logic        r_st, r_rv;
  logic [31:0] r_tgt;
  logic        seen;

  initial begin
    reset_n        = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 chk_reset_state("rst");
    #1 reset_n = 1'b1;
    #1 chk("rst_wrap_addr", w_imem_addr, PCW);

    // stream, then a three-cycle stall that parks the word at 0x108
    step(1'b0, 1'b0, 32'h0);
    chk("first_bubble", {31'h0, if_id_r.do_not_execute}, 32'h1);
    chk("wrap_bubble", {31'h0, w_if_id_r.do_not_execute}, 32'h1);
    step(1'b0, 1'b0, 32'h0);
    chk("first_pc", if_id_r.pc, 32'h100);
    chk("wrap_pc0", w_if_id_r.pc, 32'hFFFF_FFF8);
    step(1'b0, 1'b0, 32'h0);
    chk("second_pc", if_id_r.pc, 32'h104);
    chk("wrap_pc1", w_if_id_r.pc, 32'hFFFF_FFFC);
    repeat (3) step(1'b1, 1'b0, 32'h0);
    chk("stall_hold_pc", if_id_r.pc, 32'h104);
    step(1'b0, 1'b0, 32'h0);
    chk("held_pc", if_id_r.pc, 32'h108);
    chk("wrap_pc2", w_if_id_r.pc, 32'h0000_0000);
    step(1'b0, 1'b0, 32'h0);
    chk("after_held_pc", if_id_r.pc, 32'h10C);
    chk("wrap_pc3", w_if_id_r.pc, 32'h0000_0004);
    chk("wrap_dne", {31'h0, w_if_id_r.do_not_execute}, 32'h0);

    // redirect to 0x200: two bubbles then the target
    step(1'b0, 1'b1, 32'h200);
    chk("redir_bub1", {31'h0, if_id_r.do_not_execute}, 32'h1);
    step(1'b0, 1'b0, 32'h0);
    chk("redir_bub2", {31'h0, if_id_r.do_not_execute}, 32'h1);
    step(1'b0, 1'b0, 32'h0);
    chk("redir_pc", if_id_r.pc, 32'h200);
    chk("redir_dne", {31'h0, if_id_r.do_not_execute}, 32'h0);

    // fill the hold buffer, then redirect while still stalled
    step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h300);
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      step(1'b0, 1'b0, 32'h0);
      if (!if_id_r.do_not_execute) begin
        seen = 1'b1;
        chk("redir_stall_pc", if_id_r.pc, 32'h300);
      end
    end
    if (!seen) chk("redir_stall_timeout", 32'h0, 32'h1);

    // random traffic with one asynchronous reset in the middle
    for (int i = 0; i < 400; i++) begin
      if (i == 200) mid_reset();
      r_st  = ($urandom_range(0, 3) == 0);
      r_rv  = ($urandom_range(0, 11) == 0);
      r_tgt = 32'h1000 + (32'($urandom_range(0, 255)) << 2);
      step(r_st, r_rv, r_tgt);
    end

    // misaligned redirect target
`ifdef FETCH_ALIGN_CHECK_EN
    @(negedge clk);
    stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h202;
    @(posedge clk);
    #1 chk("mis_flag", {31'h0, fetch_misaligned}, 32'h1);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1 chk("mis_rd_en", {31'h0, imem_rd_en}, 32'h0);
    chk("mis_addr", imem_addr, 32'h202);
    repeat (3) @(posedge clk);
    #1 chk("mis_bubble", {31'h0, if_id_r.do_not_execute}, 32'h1);
    chk("mis_sticky", {31'h0, fetch_misaligned}, 32'h1);
    mid_reset();
    #1 chk("mis_cleared", {31'h0, fetch_misaligned}, 32'h0);
`else
    step(1'b0, 1'b1, 32'h202);
    chk("mis_addr", imem_addr, 32'h200);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("mis_fetch_pc", if_id_r.pc, 32'h200);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
